// File: rtl/norm_result_fifo.sv
// norm_result_fifo: lane-checked first-word-fall-through FIFO for normalised vectors,
// with sticky overflow and lane-mismatch flags.
module norm_result_fifo #(
  parameter int DATAWIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_valid_A,
  input  logic                         i_valid_B,
  input  logic                         i_valid_C,
  input  logic                         i_valid_D,
  input  logic [DATAWIDTH:0]           i_data_A,
  input  logic [DATAWIDTH:0]           i_data_B,
  input  logic [DATAWIDTH:0]           i_data_C,
  input  logic [DATAWIDTH:0]           i_data_D,
  input  logic                         i_ready,
  input  logic                         clr_err,
  output logic                         o_valid,
  output logic [4*(DATAWIDTH+1)-1:0]   o_data,
  output logic [$clog2(DEPTH):0]       o_count,
  output logic                         o_overflow,
  output logic                         o_mismatch
);
  localparam int W = 4 * (DATAWIDTH + 1);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic ovf_q, ovf_d, mis_q, mis_d;
  logic all_v, any_v, full, pop, push;
  assign o_valid = count_q != '0;
  assign o_data = o_valid ? mem_q[rd_ptr_q] : '0;
  assign o_count = count_q;
  assign o_overflow = ovf_q;
  assign o_mismatch = mis_q;
  always_comb begin
    all_v = i_valid_A & i_valid_B & i_valid_C & i_valid_D;
    any_v = i_valid_A | i_valid_B | i_valid_C | i_valid_D;
    full = count_q == CW'(DEPTH);
    pop = o_valid & i_ready;
    push = all_v & (!full | pop);
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d = count_q + CW'(push) - CW'(pop);
    // a new error event in the clear cycle wins over clr_err
    ovf_d = (all_v & full & !pop) | (ovf_q & !clr_err);
    mis_d = (any_v & !all_v) | (mis_q & !clr_err);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      ovf_q <= 1'b0;
      mis_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      ovf_q <= ovf_d;
      mis_q <= mis_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {i_data_A, i_data_B, i_data_C, i_data_D};
  end
endmodule

// File: tb/tb_norm_result_fifo.sv
// tb_norm_result_fifo: directed scenario tasks for norm_result_fifo with hand-derived expectations.
module tb_norm_result_fifo;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i_valid_A = 0, i_valid_B = 0, i_valid_C = 0, i_valid_D = 0;
  logic [16:0] i_data_A = 0, i_data_B = 0, i_data_C = 0, i_data_D = 0;
  logic i_ready = 0, clr_err = 0;
  logic o_valid, o_overflow, o_mismatch;
  logic [67:0] o_data;
  logic [3:0] o_count;
  int pass_cnt = 0, total_cnt = 0;

  norm_result_fifo #(.DATAWIDTH(16), .DEPTH(8)) dut (
    .clk(clk), .rst(rst),
    .i_valid_A(i_valid_A), .i_valid_B(i_valid_B), .i_valid_C(i_valid_C), .i_valid_D(i_valid_D),
    .i_data_A(i_data_A), .i_data_B(i_data_B), .i_data_C(i_data_C), .i_data_D(i_data_D),
    .i_ready(i_ready), .clr_err(clr_err),
    .o_valid(o_valid), .o_data(o_data), .o_count(o_count),
    .o_overflow(o_overflow), .o_mismatch(o_mismatch)
  );

  always #5 clk = ~clk;

  function automatic logic [67:0] mk(input logic [16:0] a);
    return {a, a + 17'd1000, ~a, 17'h0AAAA};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [67:0] v);
    {i_data_A, i_data_B, i_data_C, i_data_D} = v;
    {i_valid_A, i_valid_B, i_valid_C, i_valid_D} = 4'b1111;
  endtask

  task automatic idle();
    {i_valid_A, i_valid_B, i_valid_C, i_valid_D} = 4'b0000;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total_cnt++;
    if ({o_valid, o_data, o_count, o_overflow, o_mismatch} !== 75'd0)
      $display("FAIL reset_hold: got v=%0b d=%h c=%0d ov=%0b mm=%0b, want all 0", o_valid, o_data, o_count, o_overflow, o_mismatch);
    else pass_cnt++;
    rst = 1'b0;
    tick();
    total_cnt++;
    if ({o_valid, o_data, o_count, o_overflow, o_mismatch} !== 75'd0)
      $display("FAIL reset_release: got v=%0b d=%h c=%0d ov=%0b mm=%0b, want all 0", o_valid, o_data, o_count, o_overflow, o_mismatch);
    else pass_cnt++;
  endtask

  task automatic test_single_push();
    i_ready = 1'b0;
    drive({17'h00100, 17'h00080, 17'h1FFFF, 17'h00001});
    total_cnt++;
    if (o_valid !== 1'b0 || o_data !== 68'd0)
      $display("FAIL single_no_bypass: got v=%0b d=%h, want v=0 d=0", o_valid, o_data);
    else pass_cnt++;
    tick();
    idle();
    total_cnt++;
    if (o_valid !== 1'b1 || o_data !== {17'h00100, 17'h00080, 17'h1FFFF, 17'h00001} || o_count !== 4'd1)
      $display("FAIL single_push: got v=%0b d=%h c=%0d, want v=1 d=%h c=1", o_valid, o_data, o_count,
               {17'h00100, 17'h00080, 17'h1FFFF, 17'h00001});
    else pass_cnt++;
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    total_cnt++;
    if (o_valid !== 1'b0 || o_count !== 4'd0)
      $display("FAIL single_pop: got v=%0b c=%0d, want v=0 c=0", o_valid, o_count);
    else pass_cnt++;
  endtask

  task automatic test_fill_overflow();
    i_ready = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      drive(mk(17'(i)));
      tick();
    end
    idle();
    total_cnt++;
    if (o_count !== 4'd8 || o_overflow !== 1'b1)
      $display("FAIL fill_overflow: got c=%0d ov=%0b, want c=8 ov=1", o_count, o_overflow);
    else pass_cnt++;
    i_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      total_cnt++;
      if (o_valid !== 1'b1 || o_data !== mk(17'(i)))
        $display("FAIL fill_drain_%0d: got v=%0b d=%h, want v=1 d=%h", i, o_valid, o_data, mk(17'(i)));
      else pass_cnt++;
      tick();
    end
    i_ready = 1'b0;
    total_cnt++;
    if (o_valid !== 1'b0 || o_count !== 4'd0)
      $display("FAIL fill_ninth_absent: got v=%0b c=%0d, want v=0 c=0", o_valid, o_count);
    else pass_cnt++;
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    total_cnt++;
    if (o_overflow !== 1'b0)
      $display("FAIL overflow_clear: got ov=%0b, want 0", o_overflow);
    else pass_cnt++;
  endtask

  task automatic test_full_push_pop();
    i_ready = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      drive(mk(17'(i)));
      tick();
    end
    i_ready = 1'b1;
    drive(mk(17'h55));
    tick();
    idle();
    i_ready = 1'b0;
    total_cnt++;
    if (o_count !== 4'd8 || o_overflow !== 1'b0)
      $display("FAIL full_pushpop: got c=%0d ov=%0b, want c=8 ov=0", o_count, o_overflow);
    else pass_cnt++;
    i_ready = 1'b1;
    for (int i = 2; i <= 9; i++) begin
      total_cnt++;
      if (o_data !== mk(i == 9 ? 17'h55 : 17'(i)))
        $display("FAIL full_drain_%0d: got d=%h, want %h", i, o_data, mk(i == 9 ? 17'h55 : 17'(i)));
      else pass_cnt++;
      tick();
    end
    i_ready = 1'b0;
    total_cnt++;
    if (o_valid !== 1'b0)
      $display("FAIL full_drain_empty: got v=%0b, want 0", o_valid);
    else pass_cnt++;
  endtask

  task automatic test_mismatch();
    drive(mk(17'h33));
    tick();
    {i_valid_A, i_valid_B, i_valid_C, i_valid_D} = 4'b1010;
    tick();
    idle();
    total_cnt++;
    if (o_mismatch !== 1'b1 || o_count !== 4'd1)
      $display("FAIL mismatch_set: got mm=%0b c=%0d, want mm=1 c=1", o_mismatch, o_count);
    else pass_cnt++;
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    total_cnt++;
    if (o_mismatch !== 1'b0)
      $display("FAIL mismatch_clear: got mm=%0b, want 0", o_mismatch);
    else pass_cnt++;
    clr_err = 1'b1;
    {i_valid_A, i_valid_B, i_valid_C, i_valid_D} = 4'b0100;
    tick();
    clr_err = 1'b0;
    idle();
    total_cnt++;
    if (o_mismatch !== 1'b1 || o_count !== 4'd1 || o_data !== mk(17'h33))
      $display("FAIL mismatch_set_wins: got mm=%0b c=%0d d=%h, want mm=1 c=1 d=%h", o_mismatch, o_count, o_data, mk(17'h33));
    else pass_cnt++;
    clr_err = 1'b1;
    i_ready = 1'b1;
    tick();
    clr_err = 1'b0;
    i_ready = 1'b0;
    total_cnt++;
    if (o_mismatch !== 1'b0 || o_count !== 4'd0)
      $display("FAIL mismatch_final: got mm=%0b c=%0d, want mm=0 c=0", o_mismatch, o_count);
    else pass_cnt++;
  endtask

  task automatic test_streaming();
    logic [67:0] exp_q[$];
    int sent = 0, got = 0, errs = 0;
    for (int k = 0; k < 80 && got < 20; k++) begin
      i_ready = (k % 2 == 0);
      if (k % 2 == 0 && sent < 20) begin
        drive(mk(17'(16'h100 + sent)));
        exp_q.push_back(mk(17'(16'h100 + sent)));
        sent++;
      end else idle();
      if (o_valid && i_ready) begin
        if (exp_q.size() == 0 || o_data !== exp_q[0]) begin
          errs++;
          $display("FAIL stream_order_%0d: got d=%h", got, o_data);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        got++;
      end
      tick();
    end
    idle();
    i_ready = 1'b0;
    total_cnt++;
    if (got !== 20 || errs !== 0 || o_overflow !== 1'b0 || o_count !== 4'd0)
      $display("FAIL stream_total: got n=%0d errs=%0d ov=%0b c=%0d, want n=20 errs=0 ov=0 c=0", got, errs, o_overflow, o_count);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      drive(mk(17'(16'h200 + i)));
      tick();
    end
    {i_valid_A, i_valid_B, i_valid_C, i_valid_D} = 4'b0001;
    tick();
    idle();
    total_cnt++;
    if (o_count !== 4'd3 || o_mismatch !== 1'b1)
      $display("FAIL midrst_pre: got c=%0d mm=%0b, want c=3 mm=1", o_count, o_mismatch);
    else pass_cnt++;
    #2 rst = 1'b1;
    #1;
    total_cnt++;
    if (o_valid !== 1'b0 || o_count !== 4'd0 || o_overflow !== 1'b0 || o_mismatch !== 1'b0 || o_data !== 68'd0)
      $display("FAIL midrst_async: got v=%0b c=%0d ov=%0b mm=%0b d=%h, want all 0", o_valid, o_count, o_overflow, o_mismatch, o_data);
    else pass_cnt++;
    #2 rst = 1'b0;
    tick();
    drive(mk(17'h777));
    tick();
    drive(mk(17'h778));
    tick();
    idle();
    total_cnt++;
    if (o_valid !== 1'b1 || o_count !== 4'd2 || o_data !== mk(17'h777))
      $display("FAIL midrst_push: got v=%0b c=%0d d=%h, want v=1 c=2 d=%h", o_valid, o_count, o_data, mk(17'h777));
    else pass_cnt++;
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    total_cnt++;
    if (o_count !== 4'd1 || o_data !== mk(17'h778))
      $display("FAIL midrst_second: got c=%0d d=%h, want c=1 d=%h", o_count, o_data, mk(17'h778));
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single_push();
    test_fill_overflow();
    test_full_push_pop();
    test_mismatch();
    test_streaming();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/norm_result_fifo.md
# norm_result_fifo

Output collector directly downstream of the vector-normalisation pipeline. It captures the four per-lane quotients (A, B, C, D) and their valid strobes from the dividers, checks that the lanes arrive together, and packs each normalised vector into one word. Words are buffered in a first-word-fall-through FIFO and presented to the consumer on a valid/ready handshake. The normaliser has no backpressure, so this block absorbs bursts and flags overflow and lane-misalignment as sticky errors.

## Interface
Parameters:
- DATAWIDTH, 16, input sample width; each lane result is DATAWIDTH+1 bits.
- DEPTH, 8, FIFO entries; must be a power of two and at least 2.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-high reset.
- i_valid_A / i_valid_B / i_valid_C / i_valid_D  input  1 each  lane result strobes from the dividers.
- i_data_A / i_data_B / i_data_C / i_data_D  input  DATAWIDTH+1 each  lane quotients.
- i_ready  input  1  consumer accepts o_data this cycle.
- clr_err  input  1  synchronous clear of the sticky error flags.
- o_valid  output  1  FIFO non-empty; o_data is valid.
- o_data  output  4*(DATAWIDTH+1)  head entry, packed {A, B, C, D} with A in the MSBs.
- o_count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- o_overflow  output  1  sticky: a vector was dropped because the FIFO was full.
- o_mismatch  output  1  sticky: lane valids disagreed in some cycle.

## Operation
- **Lane check.**
  - push_req = all four i_valid_* high.
  - If any but not all of the i_valid_* are high, the cycle is a mismatch: o_mismatch is set and nothing is written.
  - If no i_valid_* is high, the cycle is idle.
- **Pop.** pop = o_valid && i_ready. The read pointer advances modulo DEPTH.
- **Push.** push = push_req && (count < DEPTH || pop).
  - A push writes {i_data_A, i_data_B, i_data_C, i_data_D} at the write pointer, which then advances modulo DEPTH.
  - A write into a full FIFO is accepted if a pop happens in the same cycle.
- **Overflow.** push_req while full and no pop: the vector is dropped, o_overflow is set, and count is unchanged.
- **Occupancy.**
  - count changes by +1 on push only, by −1 on pop only, and is unchanged on push and pop together.
  - o_count = count.
- **Output.**
  - o_valid = (count != 0).
  - o_data is read combinationally from the entry at the read pointer (first-word fall-through).
  - o_data is forced to 0 whenever o_valid is low.
- **Error flags.**
  - clr_err clears o_overflow and o_mismatch on the next clock edge.
  - If a new error event occurs in the same cycle as clr_err, the set wins.
  - The error flags never affect data flow.
- **Pointers.** Read and write pointers are $clog2(DEPTH) bits and wrap naturally. Full and empty are derived from count, not from pointer equality.
- **Storage.** The memory array is not reset. Only the pointers, count and flags are reset.

## Timing
- **Reset.** While rst is asserted, and immediately after it deasserts:
  - o_valid = 0, o_data = 0, o_count = 0;
  - o_overflow = 0, o_mismatch = 0;
  - both pointers = 0.
- **Reset mid-operation.** All buffered entries are discarded asynchronously. The first post-reset push is stored at entry 0.
- **Write latency.** A vector pushed at edge N is visible on o_data, with o_valid = 1, from edge N+1.
- **Pop timing.** A pop at edge N presents the next entry, or o_valid = 0, from edge N+1.
- **Empty FIFO.** A push into an empty FIFO does not bypass to o_data in the same cycle. Latency is always 1 cycle.
- **Empty with push and i_ready high.** No pop occurs (o_valid = 0). The push is stored.
- **Throughput.** One push and one pop per cycle, sustained, at any occupancy.

## Test plan
- **Reset values and single push.** Assert rst, then release. Drive all four valids for one cycle with A=0x00100, B=0x00080, C=0x1FFFF, D=0x00001, with i_ready=0.
  - Required: o_valid=0 and o_data=0 before the push.
  - Required: o_valid=1, o_data={0x00100, 0x00080, 0x1FFFF, 0x00001} and o_count=1 one cycle after the push.
- **Fill, then overflow.** Push 9 vectors (A = 1..9) with i_ready=0 and DEPTH=8.
  - Required: o_count saturates at 8 and o_overflow=1.
  - Required: draining returns A = 1..8 in order, and vector 9 is absent.
- **Full with simultaneous push and pop.** With the FIFO full and i_ready=1, push A=0x55.
  - Required: o_count stays 8, o_overflow stays 0, and 0x55 is the last entry drained.
- **Lane mismatch.** Drive only i_valid_A and i_valid_C high for one cycle.
  - Required: o_mismatch=1 and o_count unchanged.
  - Required: clr_err for one cycle returns o_mismatch to 0.
  - Required: clr_err coincident with another mismatch leaves o_mismatch=1.
- **Wrap-around streaming.** Stream 20 consecutive vectors with i_ready toggling 1,0,1,0.
  - Required: all 20 vectors emerge in order with no loss, and the pointers wrap past DEPTH.
- **Reset mid-operation.** With 3 entries buffered, pulse rst asynchronously between clock edges.
  - Required: o_valid, o_count and both flags drop to 0 immediately.
  - Required: the next push reads back correctly after 1 cycle.
